// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache line controller.
// Holds the controller state encoding and helpers that derive the tag,
// index and word-offset widths from the cache geometry parameters.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_REQ  = 3'd2,
        S_FILL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = 4;

    // Tag bits: everything above the cache-size boundary.
    function automatic int tag_width(input int mem_scale, input int scale);
        return mem_scale - scale;
    endfunction

    // Line index bits: between the line boundary and the cache-size boundary.
    function automatic int index_width(input int scale, input int line_scale);
        return scale - line_scale;
    endfunction

    // Word-within-line offset bits (zero for one-word lines).
    function automatic int woff_width(input int line_scale);
        return line_scale - 2;
    endfunction

    // Beat counter width; kept at least one bit so one-word lines still elaborate.
    function automatic int beat_cnt_width(input int line_scale);
        return (line_scale > 2) ? line_scale - 2 : 1;
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Dual-port, byte-writable word RAM holding the cache data.
//   clk            : clock
//   en0            : port 0 read enable; rdata0 updates on the next edge
//   addr0/we0/wdata0 : port 0 (CPU) word address, byte enables, store data
//   rdata0         : port 0 registered read data (holds between reads)
//   addr1/we1/wdata1 : port 1 (refill) word address, byte enables, data
// Contents are not reset.
module dcache_data_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en0,
    input  logic [AW-1:0] addr0,
    input  logic [3:0]    we0,
    input  logic [31:0]   wdata0,
    output logic [31:0]   rdata0,
    input  logic [AW-1:0] addr1,
    input  logic [3:0]    we1,
    input  logic [31:0]   wdata1
);

    logic [31:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (en0) begin
            rdata0 <= mem[addr0];
        end
        for (int b = 0; b < 4; b++) begin
            if (we0[b]) begin
                mem[addr0][8*b +: 8] <= wdata0[8*b +: 8];
            end
            if (we1[b]) begin
                mem[addr1][8*b +: 8] <= wdata1[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_line.sv
// Direct-mapped, write-no-allocate data cache with byte-granular valid bits.
//   clk, rst_n     : clock, asynchronous active-low reset
//   oe, addr       : read request and word-aligned byte address
//   wdata, we      : store data and byte enables (store when oe=0, we!=0)
//   rdata, hit     : read data and registered hit, one cycle after oe
//   busy           : requests are ignored while high
//   flush          : pulse invalidating every line
//   mem_req, mem_addr, mem_ack : line refill request handshake
//   mem_rvalid, mem_rdata      : refill beats, word 0 first
// A read miss retags the line, fetches it from memory and returns to IDLE;
// the CPU reissues the read afterwards.
module dcache_line
    import dcache_pkg::*;
#(
    parameter int MEM_SCALE  = 27,
    parameter int SCALE      = 10,
    parameter int LINE_SCALE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 oe,
    input  logic [MEM_SCALE-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           we,
    output logic [31:0]          rdata,
    output logic                 hit,
    output logic                 busy,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [MEM_SCALE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata
);

    localparam int TAG_W  = tag_width(MEM_SCALE, SCALE);
    localparam int IDX_W  = index_width(SCALE, LINE_SCALE);
    localparam int WOFF_W = woff_width(LINE_SCALE);
    localparam int CNT_W  = beat_cnt_width(LINE_SCALE);
    localparam int LINES  = 1 << IDX_W;
    localparam int WORDS  = 1 << WOFF_W;
    localparam int RAM_AW = SCALE - 2;

    // Controller state
    state_t             state_q;
    logic [IDX_W-1:0]   sweep_q;
    logic [CNT_W-1:0]   beat_q;
    logic               busy_q;
    logic               mem_req_q;
    logic               flush_pend_q;
    logic               hit_p1;

    // Miss capture
    logic [TAG_W-1:0]   miss_tag_q;
    logic [IDX_W-1:0]   miss_idx_q;

    // Tag and byte-valid storage
    logic [TAG_W-1:0]          tag_q   [LINES];
    logic [WORDS-1:0][3:0]     valid_q [LINES];

    // Address decode
    logic [TAG_W-1:0]   a_tag;
    logic [IDX_W-1:0]   a_idx;
    logic [CNT_W-1:0]   a_woff;
    logic [RAM_AW-1:0]  cpu_ram_addr;
    logic [RAM_AW-1:0]  fill_ram_addr;

    logic               tag_match;
    logic [3:0]         word_valid;
    logic               rd_hit;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;

    assign a_tag         = addr[MEM_SCALE-1:SCALE];
    assign a_idx         = addr[SCALE-1:LINE_SCALE];
    assign a_woff        = CNT_W'(addr[LINE_SCALE-1:0] >> 2);
    assign cpu_ram_addr  = RAM_AW'(addr[SCALE-1:0] >> 2);
    assign fill_ram_addr = (RAM_AW'(miss_idx_q) << WOFF_W) | RAM_AW'(beat_q);

    assign tag_match  = (tag_q[a_idx] == a_tag);
    assign word_valid = valid_q[a_idx][a_woff];
    assign rd_hit     = tag_match && (&word_valid);

    // A flush arriving in IDLE wins over a simultaneous request.
    assign accept = (state_q == S_IDLE) && !flush;
    assign rd_acc = accept && oe;
    assign wr_acc = accept && !oe && (|we);

    // Controller FSM; every output it drives is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            sweep_q      <= '0;
            beat_q       <= '0;
            hit_p1       <= 1'b0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b1;
            flush_pend_q <= 1'b0;
        end else begin
            hit_p1 <= 1'b0;
            if (flush && (state_q != S_IDLE)) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                S_INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == IDX_W'(LINES - 1)) begin
                        // A flush seen during the sweep restarts it; sweep_q wraps to 0.
                        if (flush_pend_q || flush) begin
                            flush_pend_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (flush) begin
                        state_q <= S_INIT;
                        busy_q  <= 1'b1;
                    end else if (rd_acc) begin
                        hit_p1 <= rd_hit;
                        if (!rd_hit) begin
                            state_q   <= S_REQ;
                            busy_q    <= 1'b1;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_q   <= S_FILL;
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == CNT_W'(WORDS - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush_pend_q || flush) begin
                        state_q      <= S_INIT;
                        flush_pend_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_INIT;
                    busy_q    <= 1'b1;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc && !rd_hit) begin
            miss_tag_q <= a_tag;
            miss_idx_q <= a_idx;
        end
    end

    // Tag/valid updates; only valid bits carry meaning after reset.
    always_ff @(posedge clk) begin
        case (state_q)
            S_INIT: begin
                valid_q[sweep_q] <= '0;
            end
            S_IDLE: begin
                if (wr_acc) begin
                    if (tag_match) begin
                        valid_q[a_idx][a_woff] <= word_valid | we;
                    end else begin
                        // Write-no-allocate: retag and keep only the bytes just stored.
                        tag_q[a_idx]           <= a_tag;
                        valid_q[a_idx]         <= '0;
                        valid_q[a_idx][a_woff] <= we;
                    end
                end
            end
            S_REQ: begin
                tag_q[miss_idx_q]   <= miss_tag_q;
                valid_q[miss_idx_q] <= '0;
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    valid_q[miss_idx_q][beat_q] <= 4'hF;
                end
            end
            default: ;
        endcase
    end

    dcache_data_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk    (clk),
        .en0    (rd_acc),
        .addr0  (cpu_ram_addr),
        .we0    (wr_acc ? we : 4'b0000),
        .wdata0 (wdata),
        .rdata0 (rdata),
        .addr1  (fill_ram_addr),
        .we1    ((state_q == S_FILL && mem_rvalid) ? 4'hF : 4'h0),
        .wdata1 (mem_rdata)
    );

    assign hit      = hit_p1;
    assign busy     = busy_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = {miss_tag_q, miss_idx_q, {LINE_SCALE{1'b0}}};

endmodule

// File: tb/tb_dcache_line.sv
module tb_dcache_line;

    logic        clk;
    logic        rst_n;
    logic        oe;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        hit;
    logic        busy;
    logic        flush;
    logic        mem_req;
    logic [26:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    dcache_line #(
        .MEM_SCALE  (27),
        .SCALE      (10),
        .LINE_SCALE (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .oe         (oe),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .rdata      (rdata),
        .hit        (hit),
        .busy       (busy),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_store;
        logic [26:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        logic        exp_hit;
        logic [31:0] exp_rdata;
        logic [31:0] fill_base;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic do_read(input logic [26:0] a, output logic h, output logic [31:0] d);
        oe   = 1'b1;
        addr = a;
        @(negedge clk);
        h  = hit;
        d  = rdata;
        oe = 1'b0;
    endtask

    task automatic do_store(input logic [26:0] a, input logic [31:0] d, input logic [3:0] w);
        addr  = a;
        wdata = d;
        we    = w;
        @(negedge clk);
        we = 4'b0000;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout_fail(name);
    endtask

    // Answers one refill request: ack, then nbeats data words base+i.
    // flush_at selects a beat during which flush is pulsed (-1: never).
    task automatic serve_fill(input logic [31:0] base, input int nbeats, input int flush_at);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) begin
            timeout_fail("mem_req_wait");
            return;
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("mem_req_drop_after_ack", 32'(mem_req), 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(i);
            flush      = (i == flush_at);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic count_busy(output int c, output logic saw_hit);
        c       = 0;
        saw_hit = 1'b0;
        while (busy && c < 300) begin
            c++;
            if (hit) saw_hit = 1'b1;
            @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [26:0] a, input logic [31:0] d,
                                input logic [3:0] w, input logic eh, input logic [31:0] er,
                                input logic [31:0] fb);
        vec_t v;
        v.is_store  = st;
        v.a         = a;
        v.d         = d;
        v.w         = w;
        v.exp_hit   = eh;
        v.exp_rdata = er;
        v.fill_base = fb;
        return v;
    endfunction

    initial begin
        logic        h;
        logic [31:0] d;
        int          cyc;
        logic        saw;

        // Line 0x100 holds A0..A3 when the table starts.
        vecs[0]  = mk(1'b0, 27'h0000100, 32'h0,        4'h0, 1'b1, 32'h000000A0, 32'h0);
        vecs[1]  = mk(1'b0, 27'h000010C, 32'h0,        4'h0, 1'b1, 32'h000000A3, 32'h0);
        vecs[2]  = mk(1'b1, 27'h0000108, 32'h11223344, 4'b0100, 1'b0, 32'h0,     32'h0);
        vecs[3]  = mk(1'b0, 27'h0000108, 32'h0,        4'h0, 1'b1, 32'h002200A2, 32'h0);
        vecs[4]  = mk(1'b1, 27'h0002200, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0,     32'h0);
        vecs[5]  = mk(1'b0, 27'h0002200, 32'h0,        4'h0, 1'b0, 32'h0,        32'h5500);
        vecs[6]  = mk(1'b1, 27'h0002200, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,     32'h0);
        vecs[7]  = mk(1'b0, 27'h0002200, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 32'h0);
        vecs[8]  = mk(1'b0, 27'h0002204, 32'h0,        4'h0, 1'b1, 32'h00005501, 32'h0);
        vecs[9]  = mk(1'b1, 27'h0003300, 32'h12345678, 4'b1111, 1'b0, 32'h0,     32'h0);
        vecs[10] = mk(1'b0, 27'h0003300, 32'h0,        4'h0, 1'b1, 32'h12345678, 32'h0);
        vecs[11] = mk(1'b0, 27'h0003304, 32'h0,        4'h0, 1'b0, 32'h0,        32'h7700);
        vecs[12] = mk(1'b0, 27'h0003300, 32'h0,        4'h0, 1'b1, 32'h00007700, 32'h0);
        vecs[13] = mk(1'b0, 27'h7FFFFF0, 32'h0,        4'h0, 1'b0, 32'h0,        32'hC0);
        vecs[14] = mk(1'b0, 27'h7FFFFFC, 32'h0,        4'h0, 1'b1, 32'h000000C3, 32'h0);
        vecs[15] = mk(1'b0, 27'h0000104, 32'h0,        4'h0, 1'b1, 32'h000000A1, 32'h0);

        rst_n      = 1'b0;
        oe         = 1'b0;
        addr       = '0;
        wdata      = '0;
        we         = 4'b0000;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state and INIT sweep length
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_hit", 32'(hit), 32'd0);
        rst_n = 1'b1;
        count_busy(cyc, saw);
        check("init_busy_cycles", 32'(cyc), 32'd64);
        check("init_hit_seen", 32'(saw), 32'd0);

        // Cold miss on 0x100, refill, then hit on word 1
        do_read(27'h0000100, h, d);
        check("cold_hit", 32'(h), 32'd0);
        check("cold_busy", 32'(busy), 32'd1);
        check("cold_mem_req", 32'(mem_req), 32'd1);
        check("cold_mem_addr", 32'(mem_addr), 32'h100);
        serve_fill(32'hA0, 4, -1);
        wait_idle("cold_idle");
        do_read(27'h0000104, h, d);
        check("reread_hit", 32'(h), 32'd1);
        check("reread_rdata", d, 32'hA1);

        // Table of reads/stores
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_store) begin
                do_store(vecs[i].a, vecs[i].d, vecs[i].w);
                check($sformatf("v%0d_store_busy", i), 32'(busy), 32'd0);
            end else begin
                do_read(vecs[i].a, h, d);
                check($sformatf("v%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
                if (vecs[i].exp_hit) begin
                    check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
                end else begin
                    check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd1);
                    check($sformatf("v%0d_mem_addr", i), 32'(mem_addr),
                          32'(vecs[i].a & 27'h7FFFFF0));
                end
                if (mem_req) begin
                    serve_fill(vecs[i].fill_base, 4, -1);
                    wait_idle($sformatf("v%0d_idle", i));
                end
            end
        end

        // Conflict: 0x500 shares the index of 0x100
        do_read(27'h0000500, h, d);
        check("conf_500_hit", 32'(h), 32'd0);
        check("conf_500_mem_addr", 32'(mem_addr), 32'h500);
        serve_fill(32'hB0, 4, -1);
        wait_idle("conf_500_idle");
        do_read(27'h0000504, h, d);
        check("conf_504_hit", 32'(h), 32'd1);
        check("conf_504_rdata", d, 32'hB1);
        do_read(27'h0000100, h, d);
        check("conf_100_hit", 32'(h), 32'd0);
        check("conf_100_mem_addr", 32'(mem_addr), 32'h100);
        serve_fill(32'hA0, 4, -1);
        wait_idle("conf_100_idle");
        do_read(27'h0000500, h, d);
        check("conf_500_again_hit", 32'(h), 32'd0);
        serve_fill(32'hB0, 4, -1);
        wait_idle("conf_500_again_idle");
        do_read(27'h0000504, h, d);
        check("pre_flush_hit", 32'(h), 32'd1);

        // Flush during FILL: refill completes, DONE then INIT with no IDLE gap
        do_read(27'h0000600, h, d);
        check("flush_miss_hit", 32'(h), 32'd0);
        serve_fill(32'hE0, 4, 1);
        count_busy(cyc, saw);
        check("flush_busy_cycles", 32'(cyc), 32'd65);
        do_read(27'h0000504, h, d);
        check("post_flush_hit", 32'(h), 32'd0);
        serve_fill(32'hB0, 4, -1);
        wait_idle("post_flush_idle");

        // Reset during FILL after two beats
        do_read(27'h0000100, h, d);
        check("rst_fill_miss", 32'(h), 32'd0);
        serve_fill(32'hA0, 2, -1);
        rst_n = 1'b0;
        #1;
        check("rst_fill_mem_req", 32'(mem_req), 32'd0);
        check("rst_fill_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy(cyc, saw);
        check("rst_fill_init_cycles", 32'(cyc), 32'd64);
        do_read(27'h0000100, h, d);
        check("rst_fill_reread_hit", 32'(h), 32'd0);
        serve_fill(32'hA0, 4, -1);
        wait_idle("rst_fill_idle");
        do_read(27'h0000108, h, d);
        check("final_hit", 32'(h), 32'd1);
        check("final_rdata", d, 32'hA2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
